// File: rtl/enc3_pkg.sv
// Stage-3 crypto frame geometry and the key-mask builder shared by the
// encrypt and decrypt stages.
package enc3_pkg;

  localparam int FRAME_W = 78;
  localparam int DATA_W  = 60;
  localparam int SUM_W   = 61;
  localparam int RAND_W  = 11;
  localparam int TAG_W   = 6;

  localparam int X_MSB = 77;
  localparam int X_LSB = 17;
  localparam int R_MSB = 16;
  localparam int R_LSB = 6;
  localparam int T_MSB = 5;
  localparam int T_LSB = 0;

  function automatic logic [DATA_W-1:0] build_key3(input logic [RAND_W-1:0] r);
    logic [DATA_W-1:0] b;
    b[10:0]  = ~r;
    b[21:11] = r;
    b[32:22] = r;
    b[43:33] = ~r;
    b[54:44] = r;
    b[59:55] = r[4:0];
    return b;
  endfunction

endpackage

// File: rtl/dec3_pipe_stage.sv
// Valid/ready register slice; accepts whenever empty or draining, so a
// full chain of slices sustains one transfer per cycle.
module dec3_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/decrypt_function_3.sv
// Stage-3 decryptor: rebuilds the key mask, recovers data = x - b over two
// pipeline slices. Range check and error counter only with DEC3_ERR_CHECK_EN.
module decrypt_function_3 import enc3_pkg::*; #(
  parameter int ERRCNT_W   = 8,
  parameter int FRAMECNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FRAME_W-1:0]    inEnc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     outDec,
  output logic [TAG_W-1:0]      outTag,
  output logic                  out_err,
  output logic [ERRCNT_W-1:0]   err_cnt,
  output logic [FRAMECNT_W-1:0] frame_cnt
);

  localparam int S1_W = SUM_W + TAG_W + DATA_W;
  localparam int S2_W = DATA_W + TAG_W + 1;

  logic [S1_W-1:0]   s1_in, s1_q;
  logic              s1_v, s2_in_ready;
  logic [SUM_W-1:0]  s1_x;
  logic [TAG_W-1:0]  s1_tag;
  logic [DATA_W-1:0] s1_b;
  logic [SUM_W:0]    diff;
  logic              range_err;
  logic [S2_W-1:0]   s2_in, s2_q;

  // Key mask is built before S1 so S2 only carries the subtractor.
  assign s1_in = {inEnc[X_MSB:X_LSB], inEnc[T_MSB:T_LSB],
                  build_key3(inEnc[R_MSB:R_LSB])};

  dec3_pipe_stage #(.W(S1_W)) u_s1 (
    .clk(Clk), .rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(s1_in),
    .out_valid(s1_v), .out_ready(s2_in_ready), .out_data(s1_q)
  );

  assign {s1_x, s1_tag, s1_b} = s1_q;
  assign diff = {1'b0, s1_x} - {2'b00, s1_b};

`ifdef DEC3_ERR_CHECK_EN
  // Top two bits flag either a borrow (x < b) or a result of 2^60 or more.
  assign range_err = |diff[SUM_W:DATA_W];
`else
  logic unused_diff_hi;
  assign unused_diff_hi = ^diff[SUM_W:DATA_W];
  assign range_err      = 1'b0;
`endif

  assign s2_in = {diff[DATA_W-1:0], s1_tag, range_err};

  dec3_pipe_stage #(.W(S2_W)) u_s2 (
    .clk(Clk), .rst_n(Rst_n),
    .in_valid(s1_v), .in_ready(s2_in_ready), .in_data(s2_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(s2_q)
  );

  assign {outDec, outTag, out_err} = s2_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) frame_cnt <= '0;
    else if (in_valid && in_ready) frame_cnt <= frame_cnt + 1'b1;
  end

`ifdef DEC3_ERR_CHECK_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) err_cnt <= '0;
    else if (out_valid && out_ready && out_err && !(&err_cnt))
      err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decrypt_function_3.sv
// Scoreboard bench for decrypt_function_3: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_decrypt_function_3;

`ifdef DEC3_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        Clk, Rst_n, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [77:0] inEnc;
  logic [59:0] outDec;
  logic [5:0]  outTag;
  logic [1:0]  err_cnt;
  logic [15:0] frame_cnt;

  decrypt_function_3 #(.ERRCNT_W(2), .FRAMECNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .inEnc(inEnc),
    .out_valid(out_valid), .out_ready(out_ready),
    .outDec(outDec), .outTag(outTag), .out_err(out_err),
    .err_cnt(err_cnt), .frame_cnt(frame_cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_frames = 0;
  int n_bad = 0;
  logic [66:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [67:0] prev_out;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  function automatic logic [59:0] key(input logic [10:0] r);
    return {r[4:0], r, ~r, r, r, ~r};
  endfunction

  function automatic logic [77:0] enc(input logic [59:0] d, input logic [10:0] r,
                                      input logic [5:0] t);
    logic [60:0] x;
    x = {1'b0, d} + {1'b0, key(r)};
    return {x, r, t};
  endfunction

  function automatic logic [1:0] exp_errcnt();
    if (!ERR_EN) return 2'd0;
    return (n_bad > 3) ? 2'd3 : 2'(n_bad);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold check while stalled.
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (prev_stall) begin
        total++;
        if ({out_valid, outDec, outTag, out_err} !== prev_out) begin
          bad++;
          $display("FAIL hold: got %0h expected %0h",
                   {out_valid, outDec, outTag, out_err}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got %0h expected no result",
                   {outDec, outTag, out_err});
        end else begin
          logic [66:0] e;
          e = sb.pop_front();
          if ({outDec, outTag, out_err} !== e) begin
            bad++;
            $display("FAIL result: got %0h expected %0h",
                     {outDec, outTag, out_err}, e);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, outDec, outTag, out_err};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [77:0] f, input logic [66:0] e);
    in_valid = 1'b1;
    inEnc    = f;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk);
      if (in_ready) begin
        sb.push_back(e);
        exp_frames++;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++; bad++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    in_valid = 1'b0;
  endtask

  task automatic lat_check(input string name, input logic [77:0] f, input logic [66:0] e);
    in_valid = 1'b1;
    inEnc    = f;
    @(negedge Clk);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    sb.push_back(e);
    exp_frames++;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge Clk); #1;
    chk({name, "_lat2_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge Clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1);
  end

  initial begin
    logic [59:0] d;
    logic [10:0] r;
    logic [5:0]  t;
    int c0;
    Rst_n = 1'b0; in_valid = 1'b0; inEnc = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outs", 64'({outDec, outTag, out_err}), 64'd0);
    chk("rst_counters", 64'({err_cnt, frame_cnt}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    // r=0, data 0x123: x = 0x0000FFE00000922
    lat_check("basic", {61'h0000FFE00000922, 11'd0, 6'h2A}, {60'h123, 6'h2A, 1'b0});
    drain();
    chk("basic_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    // 100 back-to-back encrypted frames, one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      d = 60'({$urandom(), $urandom()});
      r = 11'($urandom_range(0, 2047));
      t = 6'($urandom_range(0, 63));
      send(enc(d, r, t), {d, t, 1'b0});
    end
    chk("burst_cycles", 64'(cyc - c0), 64'd100);
    drain();
    chk("burst_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    chk("burst_err_cnt", 64'(err_cnt), 64'(exp_errcnt()));

    // backpressure: 3 frames offered with out_ready low
    out_ready = 1'b0;
    send(enc(60'hABCDEF, 11'h155, 6'h11), {60'hABCDEF, 6'h11, 1'b0});
    send(enc(60'hFFFFFFFFFFFFFFF, 11'h7FF, 6'h22), {60'hFFFFFFFFFFFFFFF, 6'h22, 1'b0});
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    inEnc    = enc(60'h0, 11'h2AA, 6'h33);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("stall_hold_in_ready", 64'(in_ready), 64'd0);
    end
    chk("stall_frame_cnt", 64'(frame_cnt), 64'(exp_frames));
    out_ready = 1'b1;
    send(enc(60'h0, 11'h2AA, 6'h33), {60'h0, 6'h33, 1'b0});
    drain();
    chk("stall_frame_cnt_after", 64'(frame_cnt), 64'(exp_frames));

    // range errors: x < b, then x = 2^60 + b
    send({61'h0, 11'd0, 6'h01}, {60'hFFFF001FFFFF801, 6'h01, ERR_EN});
    drain(); n_bad++;
    chk("err_under_cnt", 64'(err_cnt), 64'(exp_errcnt()));
    send({61'h10000FFE000007FF, 11'd0, 6'h02}, {60'h0, 6'h02, ERR_EN});
    drain(); n_bad++;
    chk("err_over_cnt", 64'(err_cnt), 64'(exp_errcnt()));
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) send({61'h0, 11'd0, 6'(i)}, {60'hFFFF001FFFFF801, 6'(i), ERR_EN});
      else send({61'h10000FFE000007FF, 11'd0, 6'(i)}, {60'h0, 6'(i), ERR_EN});
      n_bad++;
    end
    drain();
    chk("err_saturate", 64'(err_cnt), 64'(exp_errcnt()));

    // asynchronous reset with frames in flight
    send(enc(60'h5, 11'h001, 6'h05), {60'h5, 6'h05, 1'b0});
    send(enc(60'h6, 11'h002, 6'h06), {60'h6, 6'h06, 1'b0});
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_counters", 64'({err_cnt, frame_cnt}), 64'd0);
    chk("arst_outs", 64'({outDec, outTag, out_err}), 64'd0);
    sb.delete();
    exp_frames = 0;
    n_bad = 0;
    @(posedge Clk); #2;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    lat_check("post_rst", enc(60'h0DEADBEEF, 11'h3C3, 6'h3F), {60'h0DEADBEEF, 6'h3F, 1'b0});
    drain();
    chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(exp_frames));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
